// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - register-file dump engine with ready/valid output and running checksum
//
// Walks an address range [first_addr .. last_addr] (wrapping 31 -> 0) of a
// register file with an asynchronous read port. Each word is offered on a
// valid/ready output port, and the accepted words are summed into checksum.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   start       dump request, only looked at while idle
//   first_addr  first address of the range, latched with start
//   last_addr   last address of the range, latched with start
//   read_addr   address to the register file read port
//   read_data   combinational read data for read_addr
//   out_valid   out_data/out_addr hold a word on offer
//   out_ready   consumer accepts the word at the edge when out_valid is high
//   out_data    registered word on offer
//   out_addr    register address of out_data
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse at the end of a dump
//   checksum    mod 2^32 sum of the words accepted in the current/last dump

module reg_dump (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  first_addr,
    input  logic [4:0]  last_addr,
    output logic [4:0]  read_addr,
    input  logic [31:0] read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cur;
    logic [4:0]  last_q;
    logic [4:0]  read_addr_q;
    logic        handshake;

    assign handshake = (state == SEND) && out_ready;

    // The read port sees cur only while fetching; otherwise it keeps showing
    // the address of the most recent fetch.
    assign read_addr = (state == FETCH) ? cur : read_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (cur == last_q) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= 5'd0;
            last_q      <= 5'd0;
            read_addr_q <= 5'd0;
            out_data    <= 32'd0;
            out_addr    <= 5'd0;
            checksum    <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                cur      <= first_addr;
                last_q   <= last_addr;
                checksum <= 32'd0;
            end
            if (state == FETCH) begin
                out_data    <= read_data;
                out_addr    <= cur;
                read_addr_q <= cur;
            end
            if (handshake) begin
                checksum <= checksum + out_data;
                // cur is left on the last address when the range is complete
                if (cur != last_q) begin
                    cur <= cur + 5'd1;
                end
            end
        end
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, address width fixed at 5 bits.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request a dump; sampled only in IDLE.
REQ-005 FirstAddr  input  5  first register address to dump; latched when Start is accepted.
REQ-006 LastAddr  input  5  last register address to dump; latched when Start is accepted.
REQ-007 ReadAddr  output  5  read address to the register file's asynchronous read port.
REQ-008 ReadData  input  32  data returned combinationally for ReadAddr.
REQ-009 OutValid  output  1  OutData/OutAddr hold a valid word.
REQ-010 OutReady  input  1  consumer accepts the word when OutValid && OutReady at a rising edge.
REQ-011 OutData  output  32  registered word being offered.
REQ-012 OutAddr  output  5  register address of OutData.
REQ-013 Busy  output  1  high in any state other than IDLE.
REQ-014 Done  output  1  one-cycle pulse when the dump completes.
REQ-015 Checksum  output  32  sum mod 2^32 of all words accepted in the current or last dump.

Function
REQ-016 FSM states: IDLE, FETCH, SEND, FINISH.
REQ-017 IDLE: Start=1 -> latch FirstAddr/LastAddr, set current address Cur=FirstAddr, clear Checksum to 0, go to FETCH; Start=0 -> stay.
REQ-018 FETCH: ReadAddr=Cur; at the edge, capture ReadData into OutData and Cur into OutAddr, then go to SEND.
REQ-019 SEND: OutValid=1; OutData/OutAddr held stable until handshake.
REQ-020 Handshake in SEND: Checksum <= Checksum + OutData (mod 2^32); if Cur==LastAddr(latched) go to FINISH, else Cur <= Cur+1 (mod 32) and go to FETCH.
REQ-021 FINISH: Done=1 for exactly one cycle, then IDLE; Checksum holds until the next accepted Start.
REQ-022 OutValid=0 in IDLE, FETCH, FINISH; OutValid never drops in SEND without a handshake.
REQ-023 Word count = ((LastAddr - FirstAddr) mod 32) + 1; FirstAddr==LastAddr -> one word; LastAddr<FirstAddr -> wrap from 31 to 0.
REQ-024 Latency: Start accepted at edge N -> OutValid first high in the cycle after edge N+1; minimum 2 cycles per word.
REQ-025 Start while Busy is ignored; FirstAddr/LastAddr changes after acceptance have no effect.
REQ-026 ReadAddr = Cur in FETCH; in other states ReadAddr holds its last value.
REQ-027 Each word reflects register contents at its FETCH edge; no coherency with concurrent writes.
REQ-028 Register 0 dumps whatever the register file returns (0 by construction).

Reset
REQ-029 Reset=1 at a rising edge -> IDLE, OutValid=0, Done=0, Busy=0, Checksum=0, OutData=0, OutAddr=0, ReadAddr=0, Cur=0; overrides all other inputs.
REQ-030 Reset mid-dump aborts without a Done pulse; a new Start is accepted on the first edge after Reset deasserts.

Verification
REQ-031 Regs r[i]=i*0x10; Start, First=1, Last=3, OutReady=1 -> words (1,0x10),(2,0x20),(3,0x30), Done pulse, Checksum=0x60.
REQ-032 First=30, Last=1, r30=5, r31=6, r0=0, r1=7 -> addresses 30,31,0,1 in order, Checksum=0x12.
REQ-033 First=Last=4, r4=0xFFFFFFFF; OutReady low 5 cycles then high -> OutData stable, OutValid held all 5 cycles, one word, Checksum=0xFFFFFFFF.
REQ-034 r5=r6=0x80000000, First=5, Last=6 -> Checksum=0x00000000 (wrap mod 2^32).
REQ-035 Start pulsed again mid-dump -> ignored; Reset asserted in SEND -> OutValid=0, Busy=0, Checksum=0, no Done.
REQ-036 Full dump First=0, Last=31 with random OutReady -> 32 words, addresses 0..31, Checksum equals the reference sum.
